crc16_frame_checker: RTL

CRC16_FRAME_CHECKER -- requirements
Module: crc16_frame_checker

---
 rtl/crc16_pkg.sv | 14 +
 rtl/crc16_byte_step.sv | 25 ++
 rtl/crc16_frame_checker.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/crc16_pkg.sv
// Shared constants and FSM state type for the CRC-16 frame checker.
// CRC-16: polynomial 0x8005, init 0x0000, MSB-first, no reflection, no final XOR.
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } crc16_state_e;

endpackage

// File: rtl/crc16_byte_step.sv
// One-byte CRC-16 update, purely combinational, MSB-first.
module crc16_byte_step
    import crc16_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_crc
);

    logic [15:0] w_crc;

    // Fold the byte into the high half, then shift out 8 bits through the polynomial.
    always_comb begin
        w_crc = i_crc ^ {i_byte, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (w_crc[15]) begin
                w_crc = {w_crc[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                w_crc = {w_crc[14:0], 1'b0};
            end
        end
        o_crc = w_crc;
    end

endmodule

// File: rtl/crc16_frame_checker.sv
// CRC-16 frame checker: consumes payload + 2 CRC bytes, reports residue check,
// length error and byte count one cycle after the last byte.
// Optional payload forwarding (CRC bytes stripped) when CRC16_CHK_STRIP_EN is defined.
//
// state | meaning
// IDLE  | waiting for the first byte of a frame
// RECV  | frame in progress, accumulating CRC and count
// DONE  | one-cycle result pulse, no byte accepted
module crc16_frame_checker
    import crc16_pkg::*;
#(
    parameter int MAX_LEN = 255,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             byte_last,
    output logic             frame_ready,
    output logic             done,
    output logic             crc_ok,
    output logic             len_err,
    output logic [CNT_W-1:0] byte_count,
    output logic             busy,
    output logic [7:0]       data_out,
    output logic             data_out_valid
);

    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(3);

    crc16_state_e     r_state;
    crc16_state_e     w_state_next;
    logic             w_accept;
    logic [15:0]      r_crc;
    logic [15:0]      w_crc_base;
    logic [15:0]      w_crc_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_crc_ok;
    logic             r_len_err;
    logic             w_over;
    logic             w_len_err_acc;
    logic             w_len_err_final;

    // The first byte of a frame restarts from the initial CRC value.
    assign w_crc_base = (r_state == IDLE) ? CRC16_INIT : r_crc;

    crc16_byte_step u_step (
        .i_crc  (w_crc_base),
        .i_byte (byte_in),
        .o_crc  (w_crc_next)
    );

    // Count saturates at all-ones; length overflow is tracked separately by the
    // sticky error flag so a saturated count cannot hide an over-length frame.
    assign w_count_next    = (r_state == IDLE) ? CNT_W'(1) :
                             (r_count == '1) ? r_count : r_count + CNT_W'(1);
    assign w_over          = (r_state == RECV) && (r_count >= MAX_LEN_C);
    assign w_len_err_acc   = ((r_state == RECV) && r_len_err) || w_over;
    assign w_len_err_final = w_len_err_acc || (w_count_next < MIN_LEN_C);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        w_state_next = r_state;
        frame_ready  = 1'b0;
        done         = 1'b0;
        busy         = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                frame_ready = 1'b1;
                w_accept    = byte_valid;
                if (byte_valid) begin
                    w_state_next = byte_last ? DONE : RECV;
                end
            end
            RECV: begin
                frame_ready = 1'b1;
                busy        = 1'b1;
                w_accept    = byte_valid;
                if (byte_valid && byte_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                busy         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // CRC, count and result registers; the result lands as DONE is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc     <= CRC16_INIT;
            r_count   <= '0;
            r_crc_ok  <= 1'b0;
            r_len_err <= 1'b0;
        end else if (w_accept) begin
            r_crc   <= w_crc_next;
            r_count <= w_count_next;
            if (byte_last) begin
                r_len_err <= w_len_err_final;
                r_crc_ok  <= (w_crc_next == 16'h0000) && !w_len_err_final;
            end else begin
                r_len_err <= w_len_err_acc;
                r_crc_ok  <= 1'b0;
            end
        end
    end

    assign crc_ok     = r_crc_ok;
    assign len_err    = r_len_err;
    assign byte_count = r_count;

`ifdef CRC16_CHK_STRIP_EN
    logic [7:0] r_dly_new;
    logic [7:0] r_dly_old;
    logic [1:0] r_dly_fill;
    logic [7:0] r_data_out;
    logic       r_data_out_valid;

    // Two-byte delay line: a byte is only known to be payload once two more
    // bytes have arrived behind it; whatever remains at byte_last is the CRC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dly_new        <= 8'h00;
            r_dly_old        <= 8'h00;
            r_dly_fill       <= 2'd0;
            r_data_out       <= 8'h00;
            r_data_out_valid <= 1'b0;
        end else begin
            r_data_out_valid <= 1'b0;
            if (w_accept) begin
                if ((r_state == RECV) && (r_dly_fill == 2'd2)) begin
                    r_data_out       <= r_dly_old;
                    r_data_out_valid <= 1'b1;
                end
                r_dly_old <= r_dly_new;
                r_dly_new <= byte_in;
                if (byte_last) begin
                    r_dly_fill <= 2'd0;
                end else if (r_state == IDLE) begin
                    r_dly_fill <= 2'd1;
                end else if (r_dly_fill != 2'd2) begin
                    r_dly_fill <= r_dly_fill + 2'd1;
                end
            end
        end
    end

    assign data_out       = r_data_out;
    assign data_out_valid = r_data_out_valid;
`else
    assign data_out       = 8'h00;
    assign data_out_valid = 1'b0;
`endif

endmodule
